// File: rtl/pipe_hazard_if.sv
// Stage-control bundle between the 5-stage pipeline datapath and the hazard sequencer.
// The master side owns the stage information and mem_ack; the slave side drives the controls.
interface pipe_hazard_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        idex_memread;
    logic [4:0]  idex_rt;
    logic        exmem_branch;
    logic        exmem_branchne;
    logic        exmem_zero;
    logic        exmem_memread;
    logic        exmem_memwrite;
    logic        mem_ack;

    logic        pc_we;
    logic        ifid_we;
    logic        idex_we;
    logic        exmem_we;
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_flush;
    logic        memwb_flush;
    logic        pc_sel_branch;
    logic        mem_req;
    logic        mem_err;
    logic [15:0] stall_cnt;

    modport master (
        output id_rs, id_rt, idex_memread, idex_rt, exmem_branch, exmem_branchne,
               exmem_zero, exmem_memread, exmem_memwrite, mem_ack,
        input  pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush,
               exmem_flush, memwb_flush, pc_sel_branch, mem_req, mem_err, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, idex_memread, idex_rt, exmem_branch, exmem_branchne,
               exmem_zero, exmem_memread, exmem_memwrite, mem_ack,
        output pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush,
               exmem_flush, memwb_flush, pc_sel_branch, mem_req, mem_err, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, MEM-stage branch
// flushes and a timed req/ack wait for variable-latency data memory.
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    pipe_hazard_if.slave  hz
);
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic taken_s, lu_s, memop_s, decode_s;
    logic pc_we_s, ifid_we_s, idex_we_s, exmem_we_s;
    logic ifid_flush_s, idex_flush_s, exmem_flush_s, memwb_flush_s;
    logic pc_sel_s, mem_req_s, mem_err_s;

    assign taken_s = (hz.exmem_branch & hz.exmem_zero) | (hz.exmem_branchne & ~hz.exmem_zero);
    assign lu_s    = hz.idex_memread & (hz.idex_rt != 5'd0) &
                     ((hz.idex_rt == hz.id_rs) | (hz.idex_rt == hz.id_rt));
    assign memop_s = hz.exmem_memread | hz.exmem_memwrite;

    // State, wait counter and stall counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= 8'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state and stage-control decode
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        decode_s      = 1'b0;
        pc_we_s       = 1'b1;
        ifid_we_s     = 1'b1;
        idex_we_s     = 1'b1;
        exmem_we_s    = 1'b1;
        ifid_flush_s  = 1'b0;
        idex_flush_s  = 1'b0;
        exmem_flush_s = 1'b0;
        memwb_flush_s = 1'b0;
        pc_sel_s      = 1'b0;
        mem_req_s     = memop_s;
        mem_err_s     = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (memop_s && !hz.mem_ack) begin
                    pc_we_s       = 1'b0;
                    ifid_we_s     = 1'b0;
                    idex_we_s     = 1'b0;
                    exmem_we_s    = 1'b0;
                    memwb_flush_s = 1'b1;
                    wait_cnt_d    = 8'd0;
                    state_d       = ST_MEM_WAIT;
                end else begin
                    decode_s = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                mem_req_s = 1'b1;
                if (hz.mem_ack) begin
                    decode_s = 1'b1;
                    state_d  = ST_RUN;
                end else begin
                    pc_we_s       = 1'b0;
                    ifid_we_s     = 1'b0;
                    idex_we_s     = 1'b0;
                    exmem_we_s    = 1'b0;
                    memwb_flush_s = 1'b1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d = ST_ERR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            ST_ERR: begin
                pc_we_s    = 1'b0;
                ifid_we_s  = 1'b0;
                idex_we_s  = 1'b0;
                exmem_we_s = 1'b0;
                mem_req_s  = 1'b0;
                mem_err_s  = 1'b1;
            end
            default: begin
                // An unencodable state freezes the pipeline and reports an error.
                pc_we_s    = 1'b0;
                ifid_we_s  = 1'b0;
                idex_we_s  = 1'b0;
                exmem_we_s = 1'b0;
                mem_req_s  = 1'b0;
                mem_err_s  = 1'b1;
                state_d    = ST_ERR;
            end
        endcase

        if (decode_s) begin
            if (taken_s) begin
                pc_sel_s      = 1'b1;
                ifid_flush_s  = 1'b1;
                idex_flush_s  = 1'b1;
                exmem_flush_s = 1'b1;
            end else if (lu_s) begin
                pc_we_s      = 1'b0;
                ifid_we_s    = 1'b0;
                idex_flush_s = 1'b1;
            end else begin
                pc_sel_s = 1'b0;
            end
        end else begin
            pc_sel_s = 1'b0;
        end
    end

    // Saturating count of cycles in which the PC is held, excluding the error state
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q != ST_ERR) && !pc_we_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Reset forces every stage to hold and bubble without waiting for a clock edge
    always_comb begin
        if (!rst_n) begin
            hz.pc_we         = 1'b0;
            hz.ifid_we       = 1'b0;
            hz.idex_we       = 1'b0;
            hz.exmem_we      = 1'b0;
            hz.ifid_flush    = 1'b1;
            hz.idex_flush    = 1'b1;
            hz.exmem_flush   = 1'b1;
            hz.memwb_flush   = 1'b1;
            hz.pc_sel_branch = 1'b0;
            hz.mem_req       = 1'b0;
            hz.mem_err       = 1'b0;
        end else begin
            hz.pc_we         = pc_we_s;
            hz.ifid_we       = ifid_we_s;
            hz.idex_we       = idex_we_s;
            hz.exmem_we      = exmem_we_s;
            hz.ifid_flush    = ifid_flush_s;
            hz.idex_flush    = idex_flush_s;
            hz.exmem_flush   = exmem_flush_s;
            hz.memwb_flush   = memwb_flush_s;
            hz.pc_sel_branch = pc_sel_s;
            hz.mem_req       = mem_req_s;
            hz.mem_err       = mem_err_s;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: stimulus pushes hand-computed control vectors,
// a monitor pops and compares them on every falling edge.
module tb_pipe_hazard_ctrl;
    logic clk;
    logic rst_n;

    pipe_hazard_if hz();

    pipe_hazard_ctrl #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [26:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;

    // Vector layout: {pc,ifid,idex,exmem we}, {ifid,idex,exmem,memwb flush}, sel, req, err, stall_cnt
    function automatic logic [26:0] mk(input logic [3:0] we, input logic [3:0] fl,
                                       input logic sel, input logic req, input logic err,
                                       input logic [15:0] cnt);
        return {we, fl, sel, req, err, cnt};
    endfunction

    function automatic logic [26:0] nrm(input logic [15:0] cnt);
        return mk(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, cnt);
    endfunction

    task automatic step(input string nm, input logic [26:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.idex_memread = 1'b0; hz.idex_rt = 5'd0;
        hz.exmem_branch = 1'b0; hz.exmem_branchne = 1'b0; hz.exmem_zero = 1'b0;
        hz.exmem_memread = 1'b0; hz.exmem_memwrite = 1'b0; hz.mem_ack = 1'b0;
    endtask

    // Monitor: compare the DUT controls against the oldest pending expectation
    always @(negedge clk) begin
        logic [26:0] got;
        logic [26:0] e;
        string       nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            got = {hz.pc_we, hz.ifid_we, hz.idex_we, hz.exmem_we,
                   hz.ifid_flush, hz.idex_flush, hz.exmem_flush, hz.memwb_flush,
                   hz.pc_sel_branch, hz.mem_req, hz.mem_err, hz.stall_cnt};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got we=%b fl=%b sel=%b req=%b err=%b cnt=%0d, want we=%b fl=%b sel=%b req=%b err=%b cnt=%0d",
                         nm, got[26:23], got[22:19], got[18], got[17], got[16], got[15:0],
                         e[26:23], e[22:19], e[18], e[17], e[16], e[15:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [26:0] rst_v;
        logic [26:0] stl_v;
        logic [26:0] lu_v;
        logic [26:0] br_v;
        logic [26:0] err_v;
        rst_v = mk(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 16'd0);
        lu_v  = mk(4'b0011, 4'b0100, 1'b0, 1'b0, 1'b0, 16'd0);
        br_v  = mk(4'b1111, 4'b1110, 1'b1, 1'b0, 1'b0, 16'd2);

        rst_n = 1'b0;
        clr();
        @(posedge clk);
        #1;
        step("reset0", rst_v);
        step("reset1", rst_v);
        rst_n = 1'b1;
        step("idle", nrm(16'd0));

        // Load-use through rs, then rt, and the r0 exemption
        hz.idex_memread = 1'b1; hz.idex_rt = 5'd8; hz.id_rs = 5'd8;
        step("lu_rs", lu_v);
        clr();
        step("lu_after", nrm(16'd1));
        hz.idex_memread = 1'b1; hz.idex_rt = 5'd0;
        step("lu_r0", nrm(16'd1));
        hz.idex_rt = 5'd5; hz.id_rt = 5'd5; hz.id_rs = 5'd3;
        lu_v[15:0] = 16'd1;
        step("lu_rt", lu_v);
        clr();
        step("lu_rt_after", nrm(16'd2));

        // Branches in MEM; taken BNE overrides a simultaneous load-use
        hz.exmem_branchne = 1'b1; hz.exmem_zero = 1'b0;
        hz.idex_memread = 1'b1; hz.idex_rt = 5'd8; hz.id_rs = 5'd8;
        step("bne_taken", br_v);
        clr();
        hz.exmem_branch = 1'b1; hz.exmem_zero = 1'b0;
        step("beq_not_taken", nrm(16'd2));
        hz.exmem_zero = 1'b1;
        step("beq_taken", br_v);
        clr();
        hz.exmem_branchne = 1'b1; hz.exmem_zero = 1'b1;
        step("bne_not_taken", nrm(16'd2));
        clr();

        // Load acked after 3 wait cycles: 4 stalled cycles then advance
        hz.exmem_memread = 1'b1;
        stl_v = mk(4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 16'd0);
        for (int i = 0; i < 4; i++) begin
            stl_v[15:0] = 16'(2 + i);
            step("mem_stall", stl_v);
        end
        hz.mem_ack = 1'b1;
        step("mem_ack", mk(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 16'd6));
        clr();
        step("mem_after", nrm(16'd6));

        // Store acked in its request cycle: no stall, controller stays in RUN
        hz.exmem_memwrite = 1'b1; hz.mem_ack = 1'b1;
        step("mem_same", mk(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 16'd6));
        clr();
        step("mem_same_after", nrm(16'd6));

        // Ack cycle in MEM_WAIT decoded as a taken branch
        hz.exmem_memread = 1'b1;
        stl_v[15:0] = 16'd6;
        step("mem_br_stall", stl_v);
        hz.mem_ack = 1'b1; hz.exmem_branch = 1'b1; hz.exmem_zero = 1'b1;
        step("mem_ack_br", mk(4'b1111, 4'b1110, 1'b1, 1'b1, 1'b0, 16'd7));
        clr();
        step("mem_br_after", nrm(16'd7));

        // Timeout: request cycle plus 4 wait cycles, then sticky ERR
        hz.exmem_memread = 1'b1;
        for (int i = 0; i < 5; i++) begin
            stl_v[15:0] = 16'(7 + i);
            step("tmo_stall", stl_v);
        end
        err_v = mk(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 16'd12);
        step("err", err_v);
        hz.mem_ack = 1'b1;
        step("err_late_ack", err_v);
        clr();
        step("err_sticky", err_v);
        rst_n = 1'b0;
        step("err_rst", rst_v);
        rst_n = 1'b1;
        step("post_err_rst", nrm(16'd0));

        // Reset asserted in the second MEM_WAIT cycle
        hz.exmem_memread = 1'b1;
        stl_v[15:0] = 16'd0;
        step("mw_stall0", stl_v);
        stl_v[15:0] = 16'd1;
        step("mw_stall1", stl_v);
        rst_n = 1'b0;
        step("mw_rst", rst_v);
        clr();
        rst_n = 1'b1;
        step("mw_rst_after", nrm(16'd0));
        hz.idex_memread = 1'b1; hz.idex_rt = 5'd9; hz.id_rt = 5'd9;
        lu_v[15:0] = 16'd0;
        step("mw_rst_lu", lu_v);
        clr();
        step("final", nrm(16'd1));

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It drives the write-enables and flush strobes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves load-use hazards, taken branches at MEM (BEQ/BNE), and variable-latency data-memory accesses through a req/ack handshake with a timeout. Outputs are decoded combinationally from registered state plus current stage inputs, and the pipeline registers sample them on the same `clk` edge.

## Interface
- TIMEOUT, 16, maximum MEM_WAIT cycles before error; legal range 1..255.
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
- idex_memread  in  1  the instruction in EX is a load.
- idex_rt  in  5  destination register of the instruction in EX.
- exmem_branch, exmem_branchne, exmem_zero  in  1 each  branch controls and ALU zero of the instruction in MEM.
- exmem_memread, exmem_memwrite  in  1 each  the instruction in MEM accesses data memory.
- mem_ack  in  1  data memory has completed the current access this cycle.
- pc_we, ifid_we, idex_we, exmem_we  out  1 each  stage-register hold controls (0 = hold).
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load a bubble (all controls 0) on this edge.
- pc_sel_branch  out  1  PC loads the branch target.
- mem_req  out  1  data-memory access request.
- mem_err  out  1  sticky memory-timeout error.
- stall_cnt  out  16  saturating count of stalled cycles.

## Operation
- Definitions:
  - taken = (exmem_branch & exmem_zero) | (exmem_branchne & ~exmem_zero).
  - lu = idex_memread & (idex_rt != 0) & (idex_rt == id_rs | idex_rt == id_rt).
  - memop = exmem_memread | exmem_memwrite.
- States: RUN, MEM_WAIT, ERR. An 8-bit wait_cnt runs in MEM_WAIT.
- Default outputs: all _we = 1, all flush = 0, pc_sel_branch = 0, mem_req = memop.
- RUN, evaluated by priority:
  1. memop & ~mem_ack: all _we = 0, memwb_flush = 1. Next state MEM_WAIT, wait_cnt <= 0.
  2. taken: pc_sel_branch = 1, pc_we = 1, ifid_flush = idex_flush = exmem_flush = 1. Any simultaneous lu is ignored.
  3. lu: pc_we = ifid_we = 0, idex_flush = 1 (bubble). exmem_we stays 1.
  4. Otherwise: all registers advance.
- MEM_WAIT: mem_req = 1, all _we = 0, memwb_flush = 1, and taken and lu are not evaluated.
  - mem_ack: this cycle is decoded exactly as RUN rules 2–4 with no stall for the memory access. Next state RUN.
  - ~mem_ack & wait_cnt == TIMEOUT-1: next state ERR.
  - Otherwise: wait_cnt increments.
- ERR: all _we = 0, all flush = 0, mem_req = 0, mem_err = 1. Only rst_n exits ERR.
- stall_cnt increments in every non-ERR cycle where pc_we = 0, and saturates at 0xFFFF.
- Branch targets and memory data are not handled here; this block sequences only.

## Timing
- Reset (rst_n low, asynchronous):
  - State = RUN, wait_cnt = 0, stall_cnt = 0, mem_err = 0.
  - While rst_n is low, forced outputs are all _we = 0, all flush = 1, mem_req = 0, pc_sel_branch = 0.
- Load-use stall lasts exactly 1 cycle, because the load leaves EX on the next edge.
- A taken branch costs 3 flushed slots and the target is fetched on the next edge, with zero cycles in the controller.
- Memory:
  - Ack in the request cycle adds 0 stall cycles.
  - Ack after N MEM_WAIT cycles stalls for N+1 cycles total.
  - A MEM_WAIT lasts at most TIMEOUT cycles; ERR is entered on the following edge.
- mem_ack is ignored outside memop/MEM_WAIT, and ignored in ERR.
- rst_n asserted during MEM_WAIT or ERR aborts immediately to RUN with counters cleared; the memory side must drop its access.
- stall_cnt is registered and updates on the edge ending each stalled cycle.

## Test plan
- Load-use: idex_memread = 1, idex_rt = 8, id_rs = 8 → 1 cycle with pc_we = ifid_we = 0 and idex_flush = 1, then normal; stall_cnt = 1. Repeat with idex_rt = 0 → no stall.
- BNE taken: exmem_branchne = 1, exmem_zero = 0, with lu also true → pc_sel_branch = 1, three flushes, pc_we = 1, no stall, stall_cnt unchanged.
- Memory latency: exmem_memread = 1, mem_ack after 3 cycles → 4 cycles of all _we = 0 with memwb_flush = 1, mem_req high throughout; pipeline advances on the ack edge; stall_cnt = 4.
- Same-cycle ack: memwrite with mem_ack = 1 in the request cycle → no stall, state stays RUN.
- Timeout with TIMEOUT = 4: memop, never ack → ERR after the 4th MEM_WAIT cycle, mem_err = 1 sticky, mem_req = 0; a late mem_ack is ignored; rst_n pulse clears to RUN with mem_err = 0.
- Reset mid-MEM_WAIT (cycle 2) → outputs take their reset values immediately; after release, state is RUN and stall_cnt = 0.
